// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package sub_serial_pkg;

  // Width of one processed digit in bits.
  localparam int DIGIT_W = 4;

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the digit counter for a given operand width; never below 1 bit.
  function automatic int cnt_width(input int width);
    int ndig;
    ndig = width / DIGIT_W;
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/sub_4bit.sv
// One 4-bit subtract slice: {bout, d4} = x4 - y4 - bin.
module sub_4bit
  import sub_serial_pkg::*;
(
  input  logic [DIGIT_W-1:0] x4,
  input  logic [DIGIT_W-1:0] y4,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d4,
  output logic               bout
);

  logic [DIGIT_W:0] full;

  // One extra bit on the left catches the borrow as the sign of the difference.
  always_comb begin
    full = {1'b0, x4} - {1'b0, y4} - {{DIGIT_W{1'b0}}, bin};
    d4   = full[DIGIT_W-1:0];
    bout = full[DIGIT_W];
  end

endmodule

// File: rtl/sub_128bit_serial.sv
// Digit-serial unsigned subtractor: diff = a - b, one 4-bit digit per clock,
// least significant digit first, with a start/busy/done handshake.
// WIDTH must be a multiple of 4 and at least 8.
module sub_128bit_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   ra, rb;   // operands, consumed from the low end
  logic               bi;       // borrow carried between digits
  logic [CNT_W-1:0]   cnt;      // index of the digit being processed
  logic [DIGIT_W-1:0] dig;
  logic               bo;

  sub_4bit u_slice (
    .x4   (ra[DIGIT_W-1:0]),
    .y4   (rb[DIGIT_W-1:0]),
    .bin  (bi),
    .d4   (dig),
    .bout (bo)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt == LAST_DIG) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Operand capture, digit-serial datapath and result shift register.
  // NOTE: the operand and result registers are cleared by reset on purpose so
  // diff/borrow read zero after reset and an aborted operation leaves no
  // residue; they are ordinary flops, not a RAM, so reset costs nothing odd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      bi     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            bi  <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          ra   <= ra >> DIGIT_W;
          rb   <= rb >> DIGIT_W;
          diff <= {dig, diff[WIDTH-1:DIGIT_W]};
          bi   <= bo;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_DIG) borrow <= bo;
        end
        default: ;
      endcase
    end
  end

endmodule
